register_array_pq: RTL and testbench

Parametrised successor to the team's register-array priority queue. Holds up to QUEUE_SIZE key/payload entries in a register array with two compare-exchange stages per cycle, and presents the best entry at the head every cycle. Adds selectable min/max ordering, per-entry valid bits, a payload field, and guarded enqueue/dequeue with error pulses. Sits between a scheduler front end and the dispatch logic.

---
 rtl/register_array_pq.sv | 133 +++++++++++++
 tb/tb_register_array_pq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/register_array_pq.sv
// register_array_pq: register-array priority queue with per-cycle two-stage compare-exchange sort
//   Parameters: QUEUE_SIZE (even, >=4), KEY_WIDTH, PAYLOAD_WIDTH, MIN_FIRST (0: largest key at head, 1: smallest)
//   Ports: CLK, RST (async, active-high); i_wrt/i_read/i_key/i_payload request an insert, remove-head or replace;
//          o_key/o_payload/o_valid show the head entry; o_full/o_empty/o_size show occupancy;
//          o_overflow/o_underflow pulse for one cycle on a rejected insert / a remove on empty;
//          o_max_occupancy/o_drop_count are the statistics outputs.
//   Optional: define REGISTER_ARRAY_PQ_STATS_EN to build the high-water mark and drop counter; otherwise both read 0.
module register_array_pq #(
   parameter int QUEUE_SIZE    = 16,
   parameter int KEY_WIDTH     = 16,
   parameter int PAYLOAD_WIDTH = 8,
   parameter int MIN_FIRST     = 0
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic                            i_wrt,
   input  logic                            i_read,
   input  logic [KEY_WIDTH-1:0]            i_key,
   input  logic [PAYLOAD_WIDTH-1:0]        i_payload,
   output logic [KEY_WIDTH-1:0]            o_key,
   output logic [PAYLOAD_WIDTH-1:0]        o_payload,
   output logic                            o_valid,
   output logic                            o_full,
   output logic                            o_empty,
   output logic [$clog2(QUEUE_SIZE):0]     o_size,
   output logic                            o_overflow,
   output logic                            o_underflow,
   output logic [$clog2(QUEUE_SIZE):0]     o_max_occupancy,
   output logic [15:0]                     o_drop_count
);
   localparam int SW = $clog2(QUEUE_SIZE) + 1;

   typedef struct packed {
      logic                     v;
      logic [KEY_WIDTH-1:0]     k;
      logic [PAYLOAD_WIDTH-1:0] p;
   } entry_t;

   entry_t        q    [QUEUE_SIZE];
   entry_t        s0   [QUEUE_SIZE];
   entry_t        s1   [QUEUE_SIZE];
   entry_t        s2   [QUEUE_SIZE];
   logic [SW-1:0] size_q, size_d;
   logic          ovf_q, unf_q;
   logic          full, empty, enq, repl, deq, ovf, unf, run;

   // invalid entries lose to any valid key; equal keys never count as better
   function automatic logic better(entry_t a, entry_t b);
      return a.v & (!b.v | (MIN_FIRST != 0 ? a.k < b.k : a.k > b.k));
   endfunction

   assign full  = size_q == SW'(QUEUE_SIZE);
   assign empty = size_q == '0;
   assign enq   = i_wrt & ((!i_read & !full) | (i_read & empty));
   assign repl  = i_wrt & i_read & !empty;
   assign deq   = !i_wrt & i_read & !empty;
   assign ovf   = i_wrt & !i_read & full;
   assign unf   = !i_wrt & i_read & empty;
   assign size_d = enq ? size_q + 1'b1 : deq ? size_q - 1'b1 : size_q;

   // Insert shifts right only up to the first invalid slot, which absorbs the shift;
   // holes left by removals may sit anywhere, so a blind shift could push a valid entry off the end.
   always_comb begin
      s0  = q;
      run = 1'b1;
      for (int i = 1; i < QUEUE_SIZE; i++) begin
         run = run & q[i-1].v;
         if (enq && run) s0[i] = q[i-1];
      end
      if (enq || repl) s0[0] = '{v: 1'b1, k: i_key, p: i_payload};
      if (deq) s0[0] = '0;
   end

   always_comb begin
      s1 = s0;
      for (int j = 0; j < QUEUE_SIZE/2; j++)
         if (better(s0[2*j+1], s0[2*j])) begin
            s1[2*j]   = s0[2*j+1];
            s1[2*j+1] = s0[2*j];
         end
   end

   always_comb begin
      s2 = s1;
      for (int j = 0; j < QUEUE_SIZE/2 - 1; j++)
         if (better(s1[2*j+2], s1[2*j+1])) begin
            s2[2*j+1] = s1[2*j+2];
            s2[2*j+2] = s1[2*j+1];
         end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         q      <= '{default: '0};
         size_q <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else begin
         q      <= s2;
         size_q <= size_d;
         ovf_q  <= ovf;
         unf_q  <= unf;
      end
   end

`ifdef REGISTER_ARRAY_PQ_STATS_EN
   logic [SW-1:0] max_q;
   logic [15:0]   drop_q;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         max_q  <= '0;
         drop_q <= '0;
      end else begin
         max_q  <= size_d > max_q ? size_d : max_q;
         drop_q <= (ovf && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
      end
   end
   assign o_max_occupancy = max_q;
   assign o_drop_count    = drop_q;
`else
   assign o_max_occupancy = '0;
   assign o_drop_count    = '0;
`endif

   assign o_key       = q[0].k;
   assign o_payload   = q[0].p;
   assign o_valid     = !empty;
   assign o_full      = full;
   assign o_empty     = empty;
   assign o_size      = size_q;
   assign o_overflow  = ovf_q;
   assign o_underflow = unf_q;
endmodule

// File: tb/tb_register_array_pq.sv
// tb_register_array_pq: max-first and min-first queues driven in lockstep, checked against multiset models
module tb_register_array_pq;
   localparam int N  = 8;
   localparam int KW = 16;
   localparam int PW = 8;
   localparam int SW = $clog2(N) + 1;

   logic          CLK = 0, RST = 1, i_wrt = 0, i_read = 0;
   logic [KW-1:0] i_key = '0;
   logic [PW-1:0] i_payload = '0;

   logic [KW-1:0] a_key, b_key;
   logic [PW-1:0] a_pay, b_pay;
   logic          a_valid, b_valid, a_full, b_full, a_empty, b_empty, a_ovf, b_ovf, a_unf, b_unf;
   logic [SW-1:0] a_size, b_size, a_maxo, b_maxo;
   logic [15:0]   a_drop, b_drop;

   register_array_pq #(.QUEUE_SIZE(N), .KEY_WIDTH(KW), .PAYLOAD_WIDTH(PW), .MIN_FIRST(0)) u_max (
      .CLK(CLK), .RST(RST), .i_wrt(i_wrt), .i_read(i_read), .i_key(i_key), .i_payload(i_payload),
      .o_key(a_key), .o_payload(a_pay), .o_valid(a_valid), .o_full(a_full), .o_empty(a_empty),
      .o_size(a_size), .o_overflow(a_ovf), .o_underflow(a_unf), .o_max_occupancy(a_maxo),
      .o_drop_count(a_drop));

   register_array_pq #(.QUEUE_SIZE(N), .KEY_WIDTH(KW), .PAYLOAD_WIDTH(PW), .MIN_FIRST(1)) u_min (
      .CLK(CLK), .RST(RST), .i_wrt(i_wrt), .i_read(i_read), .i_key(i_key), .i_payload(i_payload),
      .o_key(b_key), .o_payload(b_pay), .o_valid(b_valid), .o_full(b_full), .o_empty(b_empty),
      .o_size(b_size), .o_overflow(b_ovf), .o_underflow(b_unf), .o_max_occupancy(b_maxo),
      .o_drop_count(b_drop));

   always #5 CLK = ~CLK;

   int        checks = 0, errors = 0;
   bit [23:0] qa[$], qb[$];
   int        max_occ = 0, drops = 0;
   bit        e_ovf = 0, e_unf = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // index of the best entry in a model queue; {key,payload} packed as [23:8],[7:0]
   function automatic int best(input bit [23:0] q[$], input bit minf);
      int b = 0;
      for (int i = 1; i < q.size(); i++)
         if (minf ? q[i][23:8] < q[b][23:8] : q[i][23:8] > q[b][23:8]) b = i;
      return b;
   endfunction

   task automatic compare_all();
      bit [23:0] ha, hb;
      int        sz = qa.size();
      int        em, ed;
      ha = sz != 0 ? qa[best(qa, 0)] : 24'h0;
      hb = sz != 0 ? qb[best(qb, 1)] : 24'h0;
`ifdef REGISTER_ARRAY_PQ_STATS_EN
      em = max_occ;
      ed = drops > 16'hFFFF ? 16'hFFFF : drops;
`else
      em = 0;
      ed = 0;
`endif
      check("max_key",   a_key,   ha[23:8]);
      check("max_pay",   a_pay,   ha[7:0]);
      check("min_key",   b_key,   hb[23:8]);
      check("min_pay",   b_pay,   hb[7:0]);
      check("valid",     {a_valid, b_valid}, {2{sz != 0}});
      check("empty",     {a_empty, b_empty}, {2{sz == 0}});
      check("full",      {a_full, b_full},   {2{sz == N}});
      check("size_max",  a_size, sz);
      check("size_min",  b_size, sz);
      check("overflow",  {a_ovf, b_ovf}, {2{e_ovf}});
      check("underflow", {a_unf, b_unf}, {2{e_unf}});
      check("max_occ",   {a_maxo, b_maxo}, {SW'(em), SW'(em)});
      check("drop_cnt",  {a_drop, b_drop}, {16'(ed), 16'(ed)});
   endtask

   task automatic op(input bit w, input bit r, input bit [15:0] k, input bit [7:0] p);
      int sz = qa.size();
      i_wrt = w; i_read = r; i_key = k; i_payload = p;
      @(posedge CLK);
      #1;
      e_ovf = 0;
      e_unf = 0;
      if (w && !r) begin
         if (sz == N) begin
            e_ovf = 1;
            drops++;
         end else begin
            qa.push_back({k, p});
            qb.push_back({k, p});
         end
      end else if (!w && r) begin
         if (sz == 0) e_unf = 1;
         else begin
            qa.delete(best(qa, 0));
            qb.delete(best(qb, 1));
         end
      end else if (w && r) begin
         if (sz != 0) begin
            qa.delete(best(qa, 0));
            qb.delete(best(qb, 1));
         end
         qa.push_back({k, p});
         qb.push_back({k, p});
      end
      if (qa.size() > max_occ) max_occ = qa.size();
      i_wrt = 0; i_read = 0;
      compare_all();
   endtask

   // asserted between edges; state must clear at once, and an insert held across an edge during reset is ignored
   task automatic do_reset();
      @(negedge CLK);
      #2;
      RST = 1;
      i_wrt = 1; i_key = 16'h00EE; i_payload = 8'h11;
      #1;
      qa.delete(); qb.delete();
      max_occ = 0; drops = 0; e_ovf = 0; e_unf = 0;
      compare_all();
      @(posedge CLK);
      @(negedge CLK);
      RST = 0;
      i_wrt = 0;
      #1;
      compare_all();
   endtask

   function automatic bit [7:0] pay_of(input bit [15:0] k);
      return k[7:0] ^ k[15:8] ^ 8'h5A;
   endfunction

   initial begin
      int ka[4] = '{5, 9, 2, 7};
      int ea[8] = '{5, 9, 9, 9, 7, 5, 2, 0};
      int eb[8] = '{5, 5, 2, 2, 5, 7, 9, 0};
      int fill[8] = '{50, 3, 17, 42, 8, 29, 11, 36};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         op(1, 0, 16'(ka[i]), 8'(8'h10 + i));
         check("tp_enq_max", a_key, ea[i]);
         check("tp_enq_min", b_key, eb[i]);
      end
      for (int i = 4; i < 8; i++) begin
         op(0, 1, 0, 0);
         check("tp_deq_max", a_key, ea[i]);
         check("tp_deq_min", b_key, eb[i]);
      end
      check("tp_drained", {a_valid, a_empty, b_valid, b_empty}, 4'b0101);
      for (int i = 0; i < 8; i++) op(1, 0, 16'(fill[i]), 8'(fill[i] + 1));
      op(1, 0, 16'd100, 8'h64);
      check("tp_ovf", {a_ovf, a_size, a_key, b_key}, {1'b1, 4'd8, 16'd50, 16'd3});
      op(0, 0, 0, 0);
      check("tp_ovf_pulse", {a_ovf, b_ovf}, 2'b00);
      op(1, 1, 16'd1, 8'h01);
      check("tp_repl", {a_size, a_key, b_key}, {4'd8, 16'd42, 16'd1});
      for (int i = 0; i < 8; i++) op(0, 1, 0, 0);
      op(0, 1, 0, 0);
      check("tp_unf", {a_unf, b_unf, a_size}, {2'b11, 4'd0});
      op(1, 1, 16'h1234, 8'hAB);
      check("tp_wr_rd_empty", {a_valid, a_key, a_pay, a_size, a_unf}, {1'b1, 16'h1234, 8'hAB, 4'd1, 1'b0});
      do_reset();
      for (int n = 0; n < 10000; n++) begin
         int        r = $urandom_range(0, 9);
         bit [15:0] k = $urandom_range(0, 15) == 0 ? 16'hFFFF : 16'($urandom_range(0, 31));
         bit        enq_heavy = ((n / 400) % 2) == 0;
         if (n == 5000) do_reset();
         if (r < (enq_heavy ? 5 : 2))      op(1, 0, k, pay_of(k));
         else if (r < 7)                   op(0, 1, 0, 0);
         else if (r < 9)                   op(1, 1, k, pay_of(k));
         else                              op(0, 0, 0, 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
